cipher_host_bridge: RTL
=======================

CIPHER_HOST_BRIDGE -- requirements
Module: cipher_host_bridge

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, depth of the command FIFO (power of two, 2..16); TIMEOUT_CYCLES, default 255, handshake wait limit.
REQ-002 SHALL have ports, one per line:
 clk  in  1  sole clock, all state updates on rising edge
 rst  in  1  asynchronous, active-high reset
 cmd_valid  in  1  upstream command present
 cmd_ready  out  1  FIFO not full
 cmd_byte  in  8  byte to send to the cipher
 cmd_is_key  in  1  byte is a key byte (no output expected)
 cmd_reset_hash  in  1  request hash reset with this byte
 input_byte  out  8  to cipher, held stable while input_request is high
 is_key  out  1  to cipher
 reset_hash  out  1  to cipher
 input_request  out  1  4-phase request
 input_acknowledged  in  1  4-phase acknowledge
 output_byte_is_ready  in  1  cipher result valid
 output_byte  in  8  cipher result
 output_acknowledge  out  1  result consumed
 res_valid  out  1  encrypted byte held for downstream
 res_byte  out  8  encrypted byte
 res_ready  in  1  downstream accepts
 busy  out  1  FSM not IDLE or FIFO not empty
 timeout_err  out  1  sticky timeout flag (HANDSHAKE_TIMEOUT_EN only, else tied 0)

Function
REQ-003 SHALL push {cmd_reset_hash, cmd_is_key, cmd_byte} into the FIFO when cmd_valid and cmd_ready are both high; cmd_ready = FIFO not full, including the cycle a pop occurs.
REQ-004 SHALL implement FSM states IDLE, REQ, REL, WAIT_OUT, OUT_ACK.
REQ-005 IDLE: when FIFO not empty, SHALL pop the head, register it onto input_byte/is_key/reset_hash, and enter REQ the next cycle.
REQ-006 REQ: SHALL drive input_request=1; on input_acknowledged=1 SHALL go to REL.
REQ-007 REL: SHALL drive input_request=0; on input_acknowledged=0, SHALL go to IDLE if is_key=1, else WAIT_OUT.
REQ-008 WAIT_OUT: when output_byte_is_ready=1 and res_valid=0, SHALL capture output_byte into res_byte, set res_valid, and go to OUT_ACK; while res_valid=1, SHALL stall in WAIT_OUT.
REQ-009 OUT_ACK: SHALL drive output_acknowledge=1; on output_byte_is_ready=0 SHALL deassert it and return to IDLE.
REQ-010 res_valid SHALL clear on the cycle res_valid and res_ready are both high; a simultaneous new capture in WAIT_OUT is NOT permitted in that same cycle (capture on the next cycle).
REQ-011 input_byte/is_key/reset_hash SHALL change only in IDLE on a pop.
REQ-012 Minimum latency: pop to input_request high = 1 cycle; output_byte_is_ready high to res_valid high = 1 cycle.
REQ-013 FIFO SHALL wrap pointers modulo FIFO_DEPTH and use a count of width clog2(FIFO_DEPTH)+1; push to a full FIFO and pop from an empty FIFO SHALL be no-ops.
REQ-014 Simultaneous push and pop on a full FIFO SHALL succeed, with the count unchanged.

Reset
REQ-015 With rst=1, asynchronously: FSM=IDLE, FIFO empty, input_request=0, output_acknowledge=0, res_valid=0, res_byte=0, input_byte=0, is_key=0, reset_hash=0, timeout_err=0.
REQ-016 Reset mid-handshake SHALL drop input_request and output_acknowledge immediately and discard all queued commands.

Configuration
REQ-017 With HANDSHAKE_TIMEOUT_EN defined: a counter SHALL count cycles spent in REQ, REL, WAIT_OUT or OUT_ACK, reset on each state change; on reaching TIMEOUT_CYCLES it SHALL set timeout_err (sticky until rst) and force IDLE with both handshake outputs low; the in-flight command is dropped.
REQ-018 Without HANDSHAKE_TIMEOUT_EN: no counter, timeout_err=0, FSM waits indefinitely.

Structure
REQ-019 bridge_state_t (5-state enum) and the FIFO entry width constant (10) SHALL live in types_pkg.
REQ-020 The FIFO SHALL be one sub-module, cipher_cmd_fifo, parameterised by depth and width.

Verification
REQ-021 Key byte 0x2B, is_key=1, cipher model acks after 3 cycles -> input_request rises, falls after ack; no output_acknowledge; FSM back to IDLE.
REQ-022 Data byte 0x41, model returns 0x9C -> res_valid=1, res_byte=0x9C one cycle after output_byte_is_ready; output_acknowledge held until ready drops.
REQ-023 Push 5 commands with FIFO_DEPTH=4 while model stalls -> cmd_ready=0 after 4 (plus 1 if a pop occurred); all bytes delivered in order.
REQ-024 res_ready=0 with two data bytes queued -> second result stalls in WAIT_OUT; output_acknowledge not raised until first res consumed.
REQ-025 Assert rst during REQ -> input_request=0 the same cycle; FIFO empty, res_valid=0.
REQ-026 HANDSHAKE_TIMEOUT_EN, TIMEOUT_CYCLES=8, model never acks -> timeout_err=1 after 8 cycles in REQ; FSM IDLE; next command is processed normally.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the cipher host bridge: FSM state encoding and the queued command format.
package types_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRel,
    StWaitOut,
    StOutAck
  } bridge_state_t;

  localparam int unsigned CmdWidth = 10;

  typedef struct packed {
    logic       reset_hash;
    logic       is_key;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/cipher_cmd_fifo.sv
// Synchronous command FIFO with a first-word-fall-through head; Depth must be a power of two.
module cipher_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/cipher_host_bridge.sv
// Queues host bytes and runs the 4-phase input / output handshakes with the cipher core.
// Optional HANDSHAKE_TIMEOUT_EN adds a per-state watchdog that aborts to idle with a sticky flag.
module cipher_host_bridge
  import types_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_is_key,
  input  logic       cmd_reset_hash,
  output logic [7:0] input_byte,
  output logic       is_key,
  output logic       reset_hash,
  output logic       input_request,
  input  logic       input_acknowledged,
  input  logic       output_byte_is_ready,
  input  logic [7:0] output_byte,
  output logic       output_acknowledge,
  output logic       res_valid,
  output logic [7:0] res_byte,
  input  logic       res_ready,
  output logic       busy,
  output logic       timeout_err
);

  bridge_state_t state_q, state_d;
  cmd_t          fifo_wdata, fifo_rdata;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    in_byte_q, in_byte_d;
  logic          is_key_q, is_key_d;
  logic          reset_hash_q, reset_hash_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_byte_q, res_byte_d;
  logic          capture;
  logic          tmo_hit;

  assign fifo_wdata = '{reset_hash: cmd_reset_hash, is_key: cmd_is_key, data: cmd_byte};
  assign cmd_ready  = !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state_q == StIdle) && !fifo_empty;

  cipher_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CmdWidth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef HANDSHAKE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  // tmo_cnt_q counts completed cycles in the current state; the last permitted one aborts.
  assign tmo_hit     = (state_q != StIdle) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  always_comb begin
    tmo_cnt_d     = '0;
    timeout_err_d = timeout_err_q | tmo_hit;
    if ((state_q != StIdle) && (state_d == state_q)) tmo_cnt_d = tmo_cnt_q + TmoW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (!fifo_empty) state_d = StReq;
        StReq:     if (input_acknowledged) state_d = StRel;
        StRel:     if (!input_acknowledged) state_d = is_key_q ? StIdle : StWaitOut;
        StWaitOut: if (output_byte_is_ready && !res_valid_q) state_d = StOutAck;
        StOutAck:  if (!output_byte_is_ready) state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    input_request      = (state_q == StReq);
    output_acknowledge = (state_q == StOutAck);
    busy               = (state_q != StIdle) || !fifo_empty;
  end

  // Capture only from an empty holding register, so a release and a capture never share a cycle.
  assign capture = (state_q == StWaitOut) && output_byte_is_ready && !res_valid_q && !tmo_hit;

  always_comb begin
    in_byte_d    = in_byte_q;
    is_key_d     = is_key_q;
    reset_hash_d = reset_hash_q;
    res_valid_d  = res_valid_q;
    res_byte_d   = res_byte_q;
    if (fifo_pop) begin
      in_byte_d    = fifo_rdata.data;
      is_key_d     = fifo_rdata.is_key;
      reset_hash_d = fifo_rdata.reset_hash;
    end
    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    if (capture) begin
      res_valid_d = 1'b1;
      res_byte_d  = output_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_byte_q    <= '0;
      is_key_q     <= 1'b0;
      reset_hash_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_byte_q   <= '0;
    end else begin
      in_byte_q    <= in_byte_d;
      is_key_q     <= is_key_d;
      reset_hash_q <= reset_hash_d;
      res_valid_q  <= res_valid_d;
      res_byte_q   <= res_byte_d;
    end
  end

  assign input_byte = in_byte_q;
  assign is_key     = is_key_q;
  assign reset_hash = reset_hash_q;
  assign res_valid  = res_valid_q;
  assign res_byte   = res_byte_q;

endmodule
